// File: rtl/num2ascii_stream.sv
// num2ascii_stream: latches an unsigned value on a start pulse, converts it to
// BCD with an iterative shift-add-3 loop, and then streams the decimal digits
// as ASCII over a valid/ready handshake. Optional features are leading-zero
// suppression, a fixed decimal point and a trailing terminator character.
module num2ascii_stream #(
   parameter int         WIDTH       = 32,
   parameter int         DIGITS      = 10,
   parameter int         FRAC_DIGITS = 0,
   parameter int         TERM_EN     = 1,
   parameter logic [7:0] TERM_CHAR   = 8'h0A
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start_update,
   input  logic [WIDTH-1:0] error_rate,
   input  logic             zero_suppress,
   input  logic             ready_i,
   output logic [7:0]       char,
   output logic             valid_o,
   output logic             busy,
   output logic             done
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int PTR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [PTR_W-1:0] MS_PTR   = PTR_W'(DIGITS - 1);
   localparam logic [PTR_W-1:0] FRAC_PTR = PTR_W'(FRAC_DIGITS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONVERT,
      S_EMIT
   } state_t;

   // Kind of output position the pointer refers to while emitting.
   typedef enum logic [1:0] {
      P_DIGIT,
      P_DOT,
      P_TERM
   } phase_t;

   state_t             state_q, state_d;
   phase_t             phase_q, phase_d;
   logic [WIDTH-1:0]   val_q,   val_d;
   logic [BCD_W-1:0]   bcd_q,   bcd_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic [PTR_W-1:0]   ptr_q,   ptr_d;
   logic               supp_q,  supp_d;
   logic [7:0]         char_q,  char_d;
   logic               valid_q, valid_d;
   logic               done_q,  done_d;

   logic [BCD_W-1:0]   bcd_adj;
   logic [3:0]         digit_w [DIGITS];

   // Position that follows the one currently presented.
   phase_t             nxt_phase;
   logic [PTR_W-1:0]   nxt_ptr;
   logic               nxt_end;
   logic [7:0]         cur_char;
   logic [7:0]         nxt_char;
   logic               skip_cur;

   // Maps an output position to its ASCII code.
   function automatic logic [7:0] char_of(input phase_t ph, input logic [3:0] nib);
      logic [7:0] c;
      case (ph)
         P_DIGIT: c = 8'h30 + {4'h0, nib};
         P_DOT:   c = 8'h2E;
         default: c = TERM_CHAR;
      endcase
      return c;
   endfunction

   // Per-nibble add-3 correction ahead of each shift, plus a digit view of the
   // BCD register for the emit-side multiplexers.
   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_nib
         assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                     (bcd_q[4*gi +: 4] + 4'd3) : bcd_q[4*gi +: 4];
         assign digit_w[gi] = bcd_q[4*gi +: 4];
      end
   endgenerate

   // Successor of the current position: digits walk down, the point sits
   // after the integer units digit, and the terminator closes the string.
   always_comb begin
      nxt_phase = phase_q;
      nxt_ptr   = ptr_q;
      nxt_end   = 1'b0;
      case (phase_q)
         P_DIGIT: begin
            if ((FRAC_DIGITS > 0) && (ptr_q == FRAC_PTR)) begin
               nxt_phase = P_DOT;
            end else if (ptr_q != '0) begin
               nxt_ptr = ptr_q - PTR_W'(1);
            end else if (TERM_EN != 0) begin
               nxt_phase = P_TERM;
            end else begin
               nxt_end = 1'b1;
            end
         end
         P_DOT: begin
            nxt_phase = P_DIGIT;
            nxt_ptr   = FRAC_PTR - PTR_W'(1);
         end
         default: begin
            nxt_end = 1'b1;
         end
      endcase
   end

   // Character lookups for the current and the following position, and the
   // leading-zero skip decision (never applied at or below the units digit).
   always_comb begin
      cur_char = char_of(phase_q, digit_w[ptr_q]);
      nxt_char = char_of(nxt_phase, digit_w[nxt_ptr]);
      skip_cur = (phase_q == P_DIGIT) && supp_q &&
                 (digit_w[ptr_q] == 4'd0) && (ptr_q > FRAC_PTR);
   end

   // Next-state and datapath logic for IDLE / CONVERT / EMIT.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      val_d   = val_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      supp_d  = supp_q;
      char_d  = char_q;
      valid_d = valid_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_update) begin
               val_d   = error_rate;
               supp_d  = zero_suppress;
               bcd_d   = '0;
               cnt_d   = CNT_W'(WIDTH);
               ptr_d   = '0;
               phase_d = P_DIGIT;
               state_d = S_CONVERT;
            end
         end

         S_CONVERT: begin
            bcd_d = {bcd_adj[BCD_W-2:0], val_q[WIDTH-1]};
            val_d = val_q << 1;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_EMIT;
               ptr_d   = MS_PTR;
               phase_d = P_DIGIT;
            end
         end

         S_EMIT: begin
            if (!valid_q) begin
               // Nothing presented yet: either drop a leading zero or load
               // the first character.
               if (skip_cur) begin
                  ptr_d = ptr_q - PTR_W'(1);
               end else begin
                  char_d  = cur_char;
                  valid_d = 1'b1;
                  supp_d  = 1'b0;
               end
            end else if (ready_i) begin
               // Transfer: preload the next character so a ready sink sees
               // one character per cycle with no bubbles.
               if (nxt_end) begin
                  valid_d = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  phase_d = nxt_phase;
                  ptr_d   = nxt_ptr;
                  char_d  = nxt_char;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         phase_q <= P_DIGIT;
         val_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         ptr_q   <= '0;
         supp_q  <= 1'b0;
         char_q  <= 8'h00;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         val_q   <= val_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         supp_q  <= supp_d;
         char_q  <= char_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   assign char    = char_q;
   assign valid_o = valid_q;
   assign done    = done_q;
   assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_num2ascii_stream.sv
// Directed bench for num2ascii_stream: one default instance (no decimal point)
// and one with two fractional digits share the same stimulus.
module tb_num2ascii_stream;

   logic        CLK;
   logic        RST;
   logic        start_update;
   logic [31:0] error_rate;
   logic        zero_suppress;
   logic        ready_i;

   logic [7:0]  char0, char1;
   logic        valid0, valid1;
   logic        busy0, busy1;
   logic        done0, done1;

   int total = 0;
   int bad   = 0;

   logic [7:0] q0[$];
   logic [7:0] q1[$];

   num2ascii_stream u_dut0 (
      .CLK(CLK), .RST(RST), .start_update(start_update), .error_rate(error_rate),
      .zero_suppress(zero_suppress), .ready_i(ready_i),
      .char(char0), .valid_o(valid0), .busy(busy0), .done(done0)
   );

   num2ascii_stream #(.FRAC_DIGITS(2)) u_dut1 (
      .CLK(CLK), .RST(RST), .start_update(start_update), .error_rate(error_rate),
      .zero_suppress(zero_suppress), .ready_i(ready_i),
      .char(char1), .valid_o(valid1), .busy(busy1), .done(done1)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Capture every transferred character.
   always @(posedge CLK) begin
      if (!RST) begin
         if (valid0 && ready_i) q0.push_back(char0);
         if (valid1 && ready_i) q1.push_back(char1);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic check_str(input string tag, input string exp, input int which);
      int n;
      logic [7:0] g;
      n = (which == 0) ? q0.size() : q1.size();
      check({tag, "_len"}, 64'(n), 64'(exp.len()));
      for (int i = 0; i < exp.len(); i++) begin
         if (i < n) g = (which == 0) ? q0[i] : q1[i];
         else       g = 8'hFF;
         check($sformatf("%s_c%0d", tag, i), 64'(g), 64'(exp[i]));
      end
   endtask

   // mode: 0 plain, 1 backpressure on third char, 2 extra start during EMIT
   task automatic run(input string tag, input logic [31:0] val, input logic zs,
                      input string e0, input string e1,
                      input int first_exp, input int done_exp, input int mode);
      int k, first0, done0k;
      bit d0, d1, bp_done;
      logic [7:0] held;
      @(negedge CLK);
      RST = 1'b0;
      error_rate = val;
      zero_suppress = zs;
      start_update = 1'b1;
      q0.delete();
      q1.delete();
      @(negedge CLK);
      start_update = 1'b0;
      k = 0;
      first0 = -1; done0k = -1; d0 = 0; d1 = 0; bp_done = 0;
      check({tag, "_busy_start"}, 64'(busy0), 64'd1);
      while (!(d0 && d1) && k < 300) begin
         @(negedge CLK);
         k++;
         if (valid0 && first0 < 0) first0 = k;
         if (done0 && !d0) begin
            d0 = 1; done0k = k;
            check({tag, "_valid_at_done"}, 64'(valid0), 64'd0);
            check({tag, "_busy_at_done"}, 64'(busy0), 64'd0);
         end
         if (done1) d1 = 1;
         if (mode == 1 && !bp_done && q0.size() == 2 && valid0) begin
            held = char0;
            ready_i = 1'b0;
            for (int j = 0; j < 5; j++) begin
               @(negedge CLK);
               k++;
               check({tag, "_bp_valid"}, 64'(valid0), 64'd1);
               check({tag, "_bp_char"}, 64'(char0), 64'(held));
            end
            ready_i = 1'b1;
            bp_done = 1;
         end
         if (mode == 2 && k == 40) begin
            error_rate = 32'd99;
            start_update = 1'b1;
            @(negedge CLK);
            k++;
            start_update = 1'b0;
         end
      end
      check({tag, "_done_seen"}, 64'(d0 && d1), 64'd1);
      if (first_exp >= 0) check({tag, "_first_valid"}, 64'(first0), 64'(first_exp));
      if (done_exp >= 0)  check({tag, "_done_cycle"}, 64'(done0k), 64'(done_exp));
      @(negedge CLK);
      check({tag, "_done_pulse"}, 64'(done0), 64'd0);
      check({tag, "_idle_busy"}, 64'(busy0), 64'd0);
      check({tag, "_idle_valid"}, 64'(valid0), 64'd0);
      check_str({tag, "_d0"}, e0, 0);
      check_str({tag, "_d1"}, e1, 1);
      $display("txn %s value=%0d zs=%0d chars0=%0d chars1=%0d first=%0d done=%0d",
               tag, val, zs, q0.size(), q1.size(), first0, done0k);
   endtask

   initial begin
      int k;
      RST = 1'b1;
      start_update = 1'b0;
      error_rate = '0;
      zero_suppress = 1'b0;
      ready_i = 1'b1;
      repeat (3) @(negedge CLK);
      check("rst_char", 64'(char0), 64'h00);
      check("rst_valid", 64'(valid0), 64'd0);
      check("rst_busy", 64'(busy0), 64'd0);
      check("rst_done", 64'(done0), 64'd0);
      $display("txn reset char=%0h valid=%0d busy=%0d done=%0d", char0, valid0, busy0, done0);

      // First start coincides with reset release.
      run("v2136_zs", 32'd2136, 1'b1, "2136\n", "21.36\n", 39, 44, 0);
      run("v2136_nozs", 32'd2136, 1'b0, "0000002136\n", "00000021.36\n", 33, 44, 0);
      run("v5_zs", 32'd5, 1'b1, "5\n", "0.05\n", 42, 44, 0);
      run("v0_zs", 32'd0, 1'b1, "0\n", "0.00\n", 42, 44, 0);
      run("vmax", 32'hFFFFFFFF, 1'b1, "4294967295\n", "42949672.95\n", 33, 44, 0);
      run("bp12345", 32'd12345, 1'b1, "12345\n", "123.45\n", 38, -1, 1);
      run("ignore_start", 32'd2136, 1'b1, "2136\n", "21.36\n", 39, 44, 2);

      // Reset in the middle of EMIT.
      @(negedge CLK);
      error_rate = 32'hFFFFFFFF;
      zero_suppress = 1'b1;
      start_update = 1'b1;
      @(negedge CLK);
      start_update = 1'b0;
      k = 0;
      while (k < 36) begin
         @(negedge CLK);
         k++;
      end
      check("mid_emit_valid", 64'(valid0), 64'd1);
      RST = 1'b1;
      @(negedge CLK);
      check("rst_mid_valid", 64'(valid0), 64'd0);
      check("rst_mid_busy", 64'(busy0), 64'd0);
      check("rst_mid_char", 64'(char0), 64'h00);
      check("rst_mid_busy1", 64'(busy1), 64'd0);
      $display("txn mid_emit_reset valid=%0d busy=%0d", valid0, busy0);

      run("after_rst", 32'd2136, 1'b0, "0000002136\n", "00000021.36\n", 33, 44, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/num2ascii_stream.md
# num2ascii_stream

Parametrised binary-to-decimal ASCII serializer, successor to the fixed 32-bit error-rate formatter. Latches an unsigned WIDTH-bit value on a start pulse, converts it to BCD by iterative shift-add-3, then streams the decimal digits as ASCII characters. The stream has optional leading-zero suppression, an optional decimal point and an optional terminator. Output uses a valid/ready handshake so it can feed a UART or LCD character sink directly.

## Interface
- WIDTH, 32, width of the unsigned input value
- DIGITS, 10, decimal digit count; integration requires 10^DIGITS > 2^WIDTH-1
- FRAC_DIGITS, 0, digits right of the decimal point; 0 means no '.' (8'h2E) is emitted; must be < DIGITS
- TERM_EN, 1, when 1, append TERM_CHAR after the last digit
- TERM_CHAR, 8'h0A, terminator character
- CLK  in  1  clock; all logic is on the rising edge
- RST  in  1  synchronous, active-high reset
- start_update  in  1  start request; sampled only in IDLE
- error_rate  in  WIDTH  value to format; latched on the accepted start cycle
- zero_suppress  in  1  leading-zero suppression mode; latched with error_rate
- ready_i  in  1  sink ready
- char  out  8  ASCII character
- valid_o  out  1  char is valid
- busy  out  1  high from the cycle after an accepted start until the cycle of done
- done  out  1  one-cycle pulse after the final character is transferred

## Operation
- States: IDLE, CONVERT, EMIT.
- IDLE:
  - start_update=1 latches error_rate and zero_suppress, clears the BCD register (4*DIGITS bits) and loads the bit counter with WIDTH.
  - Next state is CONVERT.
- CONVERT:
  - Each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, value} left by 1.
  - After exactly WIDTH cycles, go to EMIT with the digit pointer at the most significant digit.
- EMIT, one position per step, from the MS digit down to digit 0, then '.', then the terminator:
  - The '.' position sits between digit FRAC_DIGITS and digit FRAC_DIGITS-1.
  - With zero_suppress=1, a leading zero digit at index > FRAC_DIGITS is skipped. Skipping costs 1 cycle with valid_o=0. The first nonzero digit ends suppression.
  - Digit index FRAC_DIGITS (the units digit of the integer part) and all digits below it are always emitted. Consequence: value 0 gives "0", never an empty string.
  - An emitted digit is 8'h30 + nibble.
  - char/valid_o are registered. Once valid_o=1, char stays stable until the cycle where valid_o&ready_i=1. The pointer advances only on that transfer.
  - After the last character (terminator, or digit 0 when TERM_EN=0) is transferred, return to IDLE and pulse done for one cycle.
- start_update while busy is ignored and not queued.
- A start in the same cycle as done is accepted (the state is IDLE).
- RST=1 at any time forces IDLE and clears the BCD register and pointer.
  - Reset values: char=8'h00, valid_o=0, busy=0, done=0.
  - A start is accepted in the first cycle with RST=0.
- With zero_suppress=0, all DIGITS digits are emitted.

## Timing
- Start accepted at edge T0. CONVERT occupies edges T0+1 through T0+WIDTH.
- First valid_o=1 appears after edge T0+WIDTH+1+S, where S is the number of skipped leading zeros.
- With ready_i held at 1: one character per cycle, no gaps after the first.
- Total cycles from start to done with ready_i=1: WIDTH + 1 + S + N, where N is the characters emitted.
- valid_o falls in the cycle after the final transfer, which is the same cycle done=1 and busy=0.
- No combinational path from ready_i to valid_o or char.

## Test plan
- Defaults, error_rate=2136, zero_suppress=1, ready_i=1 -> chars 0x32,0x31,0x33,0x36,0x0A on consecutive cycles; first valid 32+1+6 cycles after start; done one cycle after 0x0A.
- Same value with zero_suppress=0 -> "0000002136\n" (11 chars), S=0.
- FRAC_DIGITS=2: 2136 -> "21.36\n"; 5 -> "0.05\n"; 0 with suppression -> "0.00\n". Also 0 with FRAC_DIGITS=0 -> "0\n".
- error_rate=32'hFFFFFFFF -> "4294967295\n".
- Backpressure: drop ready_i for 5 cycles during the third char -> char and valid_o held stable; no char lost or duplicated.
- Second start_update during EMIT -> ignored. RST pulse mid-EMIT -> valid_o=0, busy=0 the next cycle. A fresh start after reset -> a correct, complete string.
